// File: rtl/mem_stage.sv
// Memory stage: issues aligned loads/stores on a handshake data bus, formats
// big-endian load data and retires results or errors toward write-back.
module mem_stage #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        ex_valid,
    input  logic [0:31] ex_result,
    input  logic [0:31] ex_rt,
    input  logic [0:31] ex_insn,
    input  logic [4:0]  ex_dest,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [0:31] mem_addr,
    output logic [0:3]  mem_be,
    output logic [0:31] mem_wdata,
    input  logic        mem_ack,
    input  logic [0:31] mem_rdata,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [0:31] wb_data,
    output logic [4:0]  wb_dest,
    output logic        addr_err,
    output logic        timeout_err
);

    localparam logic [0:5] OP_LB  = 6'b100000;
    localparam logic [0:5] OP_LH  = 6'b100001;
    localparam logic [0:5] OP_LW  = 6'b100011;
    localparam logic [0:5] OP_LBU = 6'b100100;
    localparam logic [0:5] OP_LHU = 6'b100101;
    localparam logic [0:5] OP_SB  = 6'b101000;
    localparam logic [0:5] OP_SH  = 6'b101001;
    localparam logic [0:5] OP_SW  = 6'b101011;
    localparam logic [8:0] TIMEOUT_LIM = 9'(MEM_TIMEOUT);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [0:5]  op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [4:0]  dest_q, dest_d;
    logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [0:31] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [0:3]  mem_be_q, mem_be_d;
    logic        wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
    logic [0:31] wb_data_q, wb_data_d;
    logic [4:0]  wb_dest_q, wb_dest_d;
    logic        addr_err_q, addr_err_d, timeout_err_q, timeout_err_d;

    logic [0:5]  opc_s;
    logic [1:0]  off_s;
    logic        is_load_s, is_store_s, is_word_s, is_half_s, misaligned_s;
    logic        ack_s, timeout_hit_s;
    logic        unused_insn_s;

    // Byte lane offset 0 is the most significant byte of the word.
    function automatic logic [0:31] load_format(input logic [0:5] op, input logic [1:0] off,
                                                input logic [0:31] rd);
        logic [0:7]  b;
        logic [0:15] h;
        case (off)
            2'd0:    b = rd[0:7];
            2'd1:    b = rd[8:15];
            2'd2:    b = rd[16:23];
            default: b = rd[24:31];
        endcase
        h = off[1] ? rd[16:31] : rd[0:15];
        case (op)
            OP_LB:   load_format = {{24{b[0]}}, b};
            OP_LBU:  load_format = {24'd0, b};
            OP_LH:   load_format = {{16{h[0]}}, h};
            OP_LHU:  load_format = {16'd0, h};
            default: load_format = rd;
        endcase
    endfunction

    function automatic logic [0:3] store_be(input logic [0:5] op, input logic [1:0] off);
        case (op)
            OP_SB:   store_be = 4'b1000 >> off;
            OP_SH:   store_be = off[1] ? 4'b0011 : 4'b1100;
            default: store_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [0:31] store_data(input logic [0:5] op, input logic [0:31] rt);
        case (op)
            OP_SB:   store_data = {4{rt[24:31]}};
            OP_SH:   store_data = {2{rt[16:31]}};
            default: store_data = rt;
        endcase
    endfunction

    assign opc_s         = ex_insn[0:5];
    assign off_s         = ex_result[30:31];
    assign unused_insn_s = ^ex_insn[6:31];
    assign ack_s         = mem_req_q & mem_ack;
    assign timeout_hit_s = ({1'b0, cnt_q} + 9'd1) == TIMEOUT_LIM;

    // Opcode decode and alignment check of the incoming execute result.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        is_word_s  = 1'b0;
        is_half_s  = 1'b0;
        case (opc_s)
            OP_LB, OP_LBU: is_load_s = 1'b1;
            OP_LH, OP_LHU: begin is_load_s = 1'b1; is_half_s = 1'b1; end
            OP_LW:         begin is_load_s = 1'b1; is_word_s = 1'b1; end
            OP_SB:         is_store_s = 1'b1;
            OP_SH:         begin is_store_s = 1'b1; is_half_s = 1'b1; end
            OP_SW:         begin is_store_s = 1'b1; is_word_s = 1'b1; end
            default:       is_load_s = 1'b0;
        endcase
        misaligned_s = (is_word_s && (off_s != 2'b00)) || (is_half_s && off_s[0]);
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: WAIT ends on a real ack or when the timeout is reached.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (ex_valid && (is_load_s || is_store_s) && !misaligned_s) state_d = S_WAIT;
                else state_d = S_IDLE;
            end
            S_WAIT: begin
                if (ack_s || timeout_hit_s) state_d = S_IDLE;
                else state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; pulses default low, everything else holds.
    always_comb begin
        cnt_d         = cnt_q;
        op_d          = op_q;
        off_d         = off_q;
        dest_d        = dest_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        wb_valid_d    = 1'b0;
        wb_we_d       = wb_we_q;
        wb_data_d     = wb_data_q;
        wb_dest_d     = wb_dest_q;
        addr_err_d    = 1'b0;
        timeout_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ex_valid) begin
                    wb_data_d = ex_result;
                    wb_dest_d = ex_dest;
                    if (!(is_load_s || is_store_s)) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = (ex_dest != 5'd0);
                    end else if (misaligned_s) begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = 1'b0;
                        addr_err_d = 1'b1;
                    end else begin
                        wb_data_d   = wb_data_q;
                        wb_dest_d   = wb_dest_q;
                        cnt_d       = 8'd0;
                        op_d        = opc_s;
                        off_d       = off_s;
                        dest_d      = ex_dest;
                        mem_req_d   = 1'b1;
                        mem_we_d    = is_store_s;
                        mem_addr_d  = {ex_result[0:29], 2'b00};
                        mem_be_d    = is_store_s ? store_be(opc_s, off_s) : 4'b1111;
                        mem_wdata_d = is_store_s ? store_data(opc_s, ex_rt) : 32'd0;
                    end
                end else begin
                    mem_req_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (ack_s) begin
                    mem_req_d  = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_dest_d  = dest_q;
                    if (mem_we_q) begin
                        wb_we_d = 1'b0;
                    end else begin
                        wb_we_d   = (dest_q != 5'd0);
                        wb_data_d = load_format(op_q, off_q, mem_rdata);
                    end
                end else if (timeout_hit_s) begin
                    mem_req_d     = 1'b0;
                    wb_valid_d    = 1'b1;
                    wb_we_d       = 1'b0;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: mem_req_d = 1'b0;
        endcase
    end

    // Datapath and output registers; reset clears every output immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q         <= 8'd0;
            op_q          <= 6'd0;
            off_q         <= 2'd0;
            dest_q        <= 5'd0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= 32'd0;
            mem_be_q      <= 4'd0;
            mem_wdata_q   <= 32'd0;
            wb_valid_q    <= 1'b0;
            wb_we_q       <= 1'b0;
            wb_data_q     <= 32'd0;
            wb_dest_q     <= 5'd0;
            addr_err_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            off_q         <= off_d;
            dest_q        <= dest_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            wb_valid_q    <= wb_valid_d;
            wb_we_q       <= wb_we_d;
            wb_data_q     <= wb_data_d;
            wb_dest_q     <= wb_dest_d;
            addr_err_q    <= addr_err_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign stall       = (state_q == S_WAIT);
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_we       = wb_we_q;
    assign wb_data     = wb_data_q;
    assign wb_dest     = wb_dest_q;
    assign addr_err    = addr_err_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage (built with a 4-cycle memory timeout).
module tb_mem_stage;

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;

    logic        clock, reset_n, ex_valid, mem_ack;
    logic [31:0] ex_result, ex_rt, ex_insn, mem_rdata;
    logic [4:0]  ex_dest;
    logic        stall, mem_req, mem_we, wb_valid, wb_we, addr_err, timeout_err;
    logic [31:0] mem_addr, mem_wdata, wb_data;
    logic [3:0]  mem_be;
    logic [4:0]  wb_dest;

    int total = 0;
    int bad   = 0;

    mem_stage #(.MEM_TIMEOUT(4)) dut (
        .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_rt(ex_rt), .ex_insn(ex_insn), .ex_dest(ex_dest), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_data(wb_data), .wb_dest(wb_dest),
        .addr_err(addr_err), .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one instruction for a single accepting edge.
    task automatic issue(input logic [5:0] op, input logic [31:0] res, input logic [31:0] rt,
                         input logic [4:0] dest);
        ex_insn   = {op, 26'd0};
        ex_result = res;
        ex_rt     = rt;
        ex_dest   = dest;
        ex_valid  = 1'b1;
        tick();
        ex_valid  = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++; if ({stall, mem_req, mem_we, wb_valid, wb_we, addr_err, timeout_err} !== 7'b0) begin
            bad++; $display("FAIL reset_ctl got %b want 0000000", {stall, mem_req, mem_we, wb_valid, wb_we, addr_err, timeout_err}); end
        total++; if ({mem_addr, mem_wdata, wb_data, mem_be, wb_dest} !== 105'd0) begin
            bad++; $display("FAIL reset_bus got %h want 0", {mem_addr, mem_wdata, wb_data, mem_be, wb_dest}); end
        tick(); tick();
        reset_n = 1'b1;
    endtask

    task automatic test_lw();
        issue(OP_LW, 32'h0000_0104, 32'd0, 5'd5);
        total++; if ({mem_req, stall, mem_we, mem_be, mem_addr} !== {3'b110, 4'b1111, 32'h0000_0104}) begin
            bad++; $display("FAIL lw_req got %b %b %b %b %h want 1 1 0 1111 00000104", mem_req, stall, mem_we, mem_be, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 32'h8899_AABB;
        tick();
        mem_ack = 1'b0;
        total++; if ({wb_valid, wb_we, wb_dest, wb_data, mem_req, stall} !== {2'b11, 5'd5, 32'h8899_AABB, 2'b00}) begin
            bad++; $display("FAIL lw_wb got v=%b we=%b d=%0d data=%h req=%b st=%b want 1 1 5 8899aabb 0 0", wb_valid, wb_we, wb_dest, wb_data, mem_req, stall); end
        tick();
        total++; if ({wb_valid, wb_data} !== {1'b0, 32'h8899_AABB}) begin
            bad++; $display("FAIL lw_hold got v=%b data=%h want 0 8899aabb", wb_valid, wb_data); end
    endtask

    task automatic test_loads();
        logic [5:0]  ops [3] = '{OP_LB, OP_LBU, OP_LH};
        logic [31:0] adr [3] = '{32'h3, 32'h3, 32'h2};
        logic [31:0] rdt [3] = '{32'h0000_00F0, 32'h0000_00F0, 32'h1234_8001};
        logic [31:0] exp [3] = '{32'hFFFF_FFF0, 32'h0000_00F0, 32'hFFFF_8001};
        for (int i = 0; i < 3; i++) begin
            issue(ops[i], adr[i], 32'd0, 5'd9);
            total++; if ({mem_req, mem_addr} !== {1'b1, 32'd0}) begin
                bad++; $display("FAIL load%0d_addr got req=%b addr=%h want 1 00000000", i, mem_req, mem_addr); end
            mem_ack = 1'b1; mem_rdata = rdt[i];
            tick();
            mem_ack = 1'b0;
            total++; if ({wb_valid, wb_we, wb_data} !== {2'b11, exp[i]}) begin
                bad++; $display("FAIL load%0d_data got v=%b we=%b %h want 1 1 %h", i, wb_valid, wb_we, wb_data, exp[i]); end
            tick();
        end
    endtask

    task automatic test_stores();
        issue(OP_SH, 32'h0000_0012, 32'h0000_BEEF, 5'd7);
        for (int i = 0; i < 2; i++) begin
            total++; if ({mem_req, stall, mem_we, mem_be, mem_addr, mem_wdata} !== {3'b111, 4'b0011, 32'h10, 32'hBEEF_BEEF}) begin
                bad++; $display("FAIL sh_req%0d got %b %b %b %b %h %h want 1 1 1 0011 00000010 beefbeef", i, mem_req, stall, mem_we, mem_be, mem_addr, mem_wdata); end
            if (i == 0) tick();
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        total++; if ({wb_valid, wb_we, mem_req} !== 3'b100) begin
            bad++; $display("FAIL sh_wb got v=%b we=%b req=%b want 1 0 0", wb_valid, wb_we, mem_req); end
        tick();
        issue(OP_SB, 32'h0000_0005, 32'h1234_5678, 5'd2);
        total++; if ({mem_we, mem_be, mem_addr, mem_wdata} !== {1'b1, 4'b0100, 32'h4, 32'h7878_7878}) begin
            bad++; $display("FAIL sb_req got %b %b %h %h want 1 0100 00000004 78787878", mem_we, mem_be, mem_addr, mem_wdata); end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        total++; if ({wb_valid, wb_we} !== 2'b10) begin
            bad++; $display("FAIL sb_wb got v=%b we=%b want 1 0", wb_valid, wb_we); end
        tick();
    endtask

    task automatic test_errors_passthru();
        issue(OP_LW, 32'h0000_0006, 32'd0, 5'd4);
        total++; if ({addr_err, wb_valid, wb_we, mem_req, stall} !== 5'b11000) begin
            bad++; $display("FAIL misalign got err=%b v=%b we=%b req=%b st=%b want 1 1 0 0 0", addr_err, wb_valid, wb_we, mem_req, stall); end
        tick();
        total++; if ({addr_err, wb_valid, mem_req} !== 3'b000) begin
            bad++; $display("FAIL misalign_pulse got err=%b v=%b req=%b want 0 0 0", addr_err, wb_valid, mem_req); end
        issue(OP_ADD, 32'h0000_0007, 32'd0, 5'd0);
        total++; if ({wb_valid, wb_we, wb_data, wb_dest} !== {2'b10, 32'h7, 5'd0}) begin
            bad++; $display("FAIL add_r0 got v=%b we=%b %h d=%0d want 1 0 00000007 0", wb_valid, wb_we, wb_data, wb_dest); end
        issue(OP_ADD, 32'hCAFE_0001, 32'd0, 5'd3);
        total++; if ({wb_valid, wb_we, wb_data, wb_dest, stall} !== {2'b11, 32'hCAFE_0001, 5'd3, 1'b0}) begin
            bad++; $display("FAIL add_r3 got v=%b we=%b %h d=%0d st=%b want 1 1 cafe0001 3 0", wb_valid, wb_we, wb_data, wb_dest, stall); end
        tick();
    endtask

    task automatic test_timeout();
        int nreq = 0;
        int nst  = 0;
        issue(OP_LW, 32'h0000_0020, 32'd0, 5'd6);
        for (int i = 0; i < 4; i++) begin
            if (mem_req) nreq++;
            if (stall) nst++;
            tick();
        end
        total++; if (nreq !== 4 || nst !== 4) begin
            bad++; $display("FAIL to_len got req=%0d stall=%0d want 4 4", nreq, nst); end
        total++; if ({timeout_err, wb_valid, wb_we, mem_req, stall} !== 5'b11000) begin
            bad++; $display("FAIL to_pulse got err=%b v=%b we=%b req=%b st=%b want 1 1 0 0 0", timeout_err, wb_valid, wb_we, mem_req, stall); end
        mem_ack = 1'b1;
        issue(OP_ADD, 32'h0000_00AA, 32'd0, 5'd1);
        mem_ack = 1'b0;
        total++; if ({wb_valid, wb_we, wb_data, timeout_err, stall} !== {2'b11, 32'hAA, 2'b00}) begin
            bad++; $display("FAIL to_next got v=%b we=%b %h err=%b st=%b want 1 1 000000aa 0 0", wb_valid, wb_we, wb_data, timeout_err, stall); end
        tick();
        issue(OP_LW, 32'h0000_0030, 32'd0, 5'd8);
        tick(); tick(); tick();
        mem_ack = 1'b1; mem_rdata = 32'h0BAD_F00D;
        tick();
        mem_ack = 1'b0;
        total++; if ({wb_valid, wb_we, timeout_err, wb_data} !== {3'b110, 32'h0BAD_F00D}) begin
            bad++; $display("FAIL ack_at_limit got v=%b we=%b err=%b %h want 1 1 0 0badf00d", wb_valid, wb_we, timeout_err, wb_data); end
        tick();
    endtask

    task automatic test_back_to_back();
        issue(OP_LW, 32'h0000_0104, 32'd0, 5'd5);
        ex_insn = {OP_ADD, 26'd0}; ex_result = 32'h0000_5555; ex_dest = 5'd10; ex_valid = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_ack = 1'b0;
        total++; if ({wb_valid, wb_data, wb_dest, stall} !== {1'b1, 32'h1111_2222, 5'd5, 1'b0}) begin
            bad++; $display("FAIL b2b_load got v=%b %h d=%0d st=%b want 1 11112222 5 0", wb_valid, wb_data, wb_dest, stall); end
        tick();
        ex_valid = 1'b0;
        total++; if ({wb_valid, wb_we, wb_data, wb_dest} !== {2'b11, 32'h0000_5555, 5'd10}) begin
            bad++; $display("FAIL b2b_pass got v=%b we=%b %h d=%0d want 1 1 00005555 10", wb_valid, wb_we, wb_data, wb_dest); end
        tick();
    endtask

    task automatic test_reset_in_wait();
        int nv = 0;
        issue(OP_LW, 32'h0000_0040, 32'd0, 5'd12);
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        total++; if ({mem_req, stall, wb_valid} !== 3'b000) begin
            bad++; $display("FAIL rst_wait got req=%b st=%b v=%b want 0 0 0", mem_req, stall, wb_valid); end
        tick();
        reset_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (wb_valid) nv++;
        end
        mem_ack = 1'b0;
        total++; if (nv !== 0 || mem_req !== 1'b0) begin
            bad++; $display("FAIL rst_late_ack got wb_valid_cycles=%0d req=%b want 0 0", nv, mem_req); end
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        issue(OP_ADD, 32'h0000_0123, 32'd0, 5'd2);
        total++; if ({wb_valid, wb_data} !== {1'b1, 32'h123}) begin
            bad++; $display("FAIL rst_first_accept got v=%b %h want 1 00000123", wb_valid, wb_data); end
    endtask

    initial begin
        reset_n = 1'b0; ex_valid = 1'b0; mem_ack = 1'b0;
        ex_result = 32'd0; ex_rt = 32'd0; ex_insn = 32'd0; ex_dest = 5'd0; mem_rdata = 32'd0;
        test_reset();
        test_lw();
        test_loads();
        test_stores();
        test_errors_passthru();
        test_timeout();
        test_back_to_back();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 MEM_TIMEOUT, 255, maximum cycles mem_req is held without mem_ack before abort (1..255).
REQ-002 clock  in  1  single clock; all state on rising edge.
REQ-003 reset_n  in  1  reset is asynchronous and active-low.
REQ-004 ex_valid  in  1  execute-stage result valid this cycle.
REQ-005 ex_result  in  32  [0:31] ALU result / effective address (bit 0 = MSB).
REQ-006 ex_rt  in  32  [0:31] store data.
REQ-007 ex_insn  in  32  [0:31] instruction; opcode = ex_insn[0:5].
REQ-008 ex_dest  in  5  destination register number.
REQ-009 stall  out  1  upstream SHALL hold its outputs while high.
REQ-010 mem_req, mem_we  out  1 each  data-memory request, write enable.
REQ-011 mem_addr  out  32  word-aligned address; mem_be out 4 byte enables, mem_be[0] = bits [0:7]; mem_wdata out 32.
REQ-012 mem_ack  in  1; mem_rdata  in  32, valid when mem_ack high.
REQ-013 wb_valid, wb_we  out  1 each; wb_data out 32; wb_dest out 5.
REQ-014 addr_err, timeout_err  out  1 each, one-cycle pulses.

Function
REQ-015 Opcodes: LB 100000, LH 100001, LW 100011, LBU 100100, LHU 100101, SB 101000, SH 101001, SW 101011; all others are pass-through.
REQ-016 States IDLE, WAIT; stall SHALL equal (state == WAIT).
REQ-017 ex_valid sampled high in IDLE at edge k = accept; ex_valid in WAIT is ignored.
REQ-018 Pass-through: wb_valid=1, wb_data=ex_result, wb_dest=ex_dest, wb_we=1 during cycle k+1; state stays IDLE.
REQ-019 Alignment: word op needs addr[30:31]=00, half op addr[31]=0; misaligned -> cycle k+1: addr_err=1, wb_valid=1, wb_we=0, no mem_req.
REQ-020 Aligned load/store: IDLE->WAIT at k; mem_req=1 from cycle k+1 until edge where mem_ack=1, mem_addr = {addr[0:29],00}, all request outputs stable while held.
REQ-021 WAIT->IDLE on edge with mem_req&mem_ack; following cycle wb_valid=1, mem_req=0, stall=0 (new accept allowed that cycle). Minimum latency ex_valid->wb_valid: 2 cycles.
REQ-022 Byte lanes big-endian: offset 0 = bits [0:7]. SB: mem_be one-hot at index offset, byte replicated to all 4 lanes. SH: mem_be 1100 (offset 0) or 0011 (offset 2), halfword replicated. SW: 1111, ex_rt unchanged. Loads: mem_we=0, mem_be=1111.
REQ-023 Load data: byte/half selected by offset; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-024 Stores complete with wb_valid=1, wb_we=0.
REQ-025 wb_we SHALL be 0 whenever wb_dest = 0.
REQ-026 wb_valid, addr_err, timeout_err are one-cycle pulses; wb_data/wb_dest hold last value otherwise.
REQ-027 Timeout: 8-bit counter cleared on entering WAIT, increments each WAIT cycle without ack; at count = MEM_TIMEOUT, drop mem_req, return IDLE, next cycle timeout_err=1, wb_valid=1, wb_we=0.
REQ-028 Ack in same cycle counter reaches MEM_TIMEOUT: ack wins, normal completion.
REQ-029 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-030 reset_n low: immediately all outputs 0, state IDLE, counter 0.
REQ-031 Reset during WAIT abandons the transaction: mem_req drops without waiting for clock, no wb_valid afterwards.
REQ-032 First accept possible at first rising edge after reset_n rises.

Verification
REQ-033 LW addr 0x00000104, ack at 1st request cycle, mem_rdata 0x8899AABB, dest 5 -> wb_valid 2 cycles after accept, wb_data 0x8899AABB, wb_we=1, wb_dest 5.
REQ-034 LB addr 0x00000003, mem_rdata 0x000000F0 -> wb_data 0xFFFFFFF0; LBU same -> 0x000000F0; LH addr 0x2, rdata 0x12348001 -> 0xFFFF8001.
REQ-035 SH addr 0x00000012, ex_rt 0x0000BEEF -> mem_addr 0x10, mem_we=1, mem_be 0011, mem_wdata 0xBEEFBEEF; wb_valid with wb_we=0.
REQ-036 LW addr 0x00000006 -> addr_err pulse, no mem_req, wb_we=0; ADD result 0x7 dest 0 -> wb_valid, wb_we=0.
REQ-037 MEM_TIMEOUT=4, mem_ack never -> mem_req exactly 4 cycles, stall high 4 cycles, then timeout_err pulse; next ex_valid accepted.
REQ-038 reset_n low 2 cycles into WAIT -> mem_req, stall 0 same cycle; late mem_ack produces no wb_valid.
